toy_bus_age_arb_lock_n: RTL and testbench

//  N-input age-matrix (least-recently-granted) arbiter for the toy_bus decode/fetch networks; merges N ToyBus

---
 rtl/toy_bus_pkg.sv | 18 +
 rtl/toy_bus_cmn_age_mtx_n.sv | 37 +++
 rtl/toy_bus_age_arb_lock_n.sv | 161 ++++++++++++++++
 tb/tb_toy_bus_age_arb_lock_n.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_bus_pkg.sv
// Shared ToyBus definitions: payload width defaults, arbiter lock-FSM states and age-matrix reset order.
package toy_bus_pkg;

  localparam int TOY_OPC_W  = 1;
  localparam int TOY_DATA_W = 32;
  localparam int TOY_ID_W   = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Reset priority: lower index is older, so age[row][col] = 1 when col < row.
  function automatic logic age_reset_bit(int row, int col);
    return (col < row);
  endfunction

endpackage

// File: rtl/toy_bus_cmn_age_mtx_n.sv
// NUM_IN x NUM_IN age matrix; age_row[i*NUM_IN+j]=1 means channel j beats channel i.
// A pulse on update_en[g] makes g the youngest channel (row g set, column g cleared).
module toy_bus_cmn_age_mtx_n
  import toy_bus_pkg::*;
#(
  parameter int NUM_IN = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IN-1:0]          update_en,
  output logic [NUM_IN*NUM_IN-1:0]   age_row
);

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_row
      for (gj = 0; gj < NUM_IN; gj++) begin : g_col
        if (gi == gj) begin : g_diag
          assign age_row[gi*NUM_IN+gj] = 1'b0;
        end else begin : g_cell
          logic age_reg;
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
              age_reg <= age_reset_bit(gi, gj);
            end else if (update_en[gi]) begin
              age_reg <= 1'b1;
            end else if (update_en[gj]) begin
              age_reg <= 1'b0;
            end
          end
          assign age_row[gi*NUM_IN+gj] = age_reg;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/toy_bus_age_arb_lock_n.sv
// Least-recently-granted ToyBus arbiter with multi-beat packet lock and grant hold under back-pressure.
// Define TOY_BUS_ARB_OUT_SLICE_EN to insert a 2-entry registered skid slice on out0_*.
module toy_bus_age_arb_lock_n
  import toy_bus_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int OPC_W  = TOY_OPC_W,
  parameter int DATA_W = TOY_DATA_W,
  parameter int ID_W   = TOY_ID_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IN-1:0]          in_vld,
  output logic [NUM_IN-1:0]          in_rdy,
  input  logic [NUM_IN-1:0]          in_last,
  input  logic [NUM_IN*OPC_W-1:0]    in_opcode,
  input  logic [NUM_IN*DATA_W-1:0]   in_data,
  input  logic [NUM_IN*ID_W-1:0]     in_src_id,
  input  logic [NUM_IN*ID_W-1:0]     in_tgt_id,
  output logic                       out0_vld,
  input  logic                       out0_rdy,
  output logic                       out0_last,
  output logic [OPC_W-1:0]           out0_opcode,
  output logic [DATA_W-1:0]          out0_data,
  output logic [ID_W-1:0]            out0_src_id,
  output logic [ID_W-1:0]            out0_tgt_id,
  output logic [NUM_IN-1:0]          out_gnt
);

  arb_state_e                 state_reg;
  logic [NUM_IN-1:0]          gnt_reg;
  logic [NUM_IN*NUM_IN-1:0]   age_row;
  logic [NUM_IN-1:0]          sel;
  logic [NUM_IN-1:0]          gnt;
  logic [NUM_IN-1:0]          update_en;
  logic                       down_rdy;
  logic                       fire;
  logic                       stall;
  logic                       mux_vld;
  logic                       mux_last;
  logic [OPC_W-1:0]           mux_opc;
  logic [DATA_W-1:0]          mux_data;
  logic [ID_W-1:0]            mux_src;
  logic [ID_W-1:0]            mux_tgt;

  toy_bus_cmn_age_mtx_n #(.NUM_IN(NUM_IN)) u_age (
    .clk       (clk),
    .rst_n     (rst_n),
    .update_en (update_en),
    .age_row   (age_row)
  );

  // A valid channel wins when no valid channel beats it.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_sel
      assign sel[gi] = in_vld[gi] & ~|(age_row[gi*NUM_IN +: NUM_IN] & in_vld);
    end
  endgenerate

  assign gnt     = (state_reg == ST_LOCKED) ? gnt_reg : sel;
  assign out_gnt = gnt;

  always_comb begin
    mux_vld  = 1'b0;
    mux_last = 1'b0;
    mux_opc  = '0;
    mux_data = '0;
    mux_src  = '0;
    mux_tgt  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      mux_vld  = mux_vld  | (in_vld[i]  & gnt[i]);
      mux_last = mux_last | (in_last[i] & gnt[i]);
      mux_opc  = mux_opc  | (in_opcode[i*OPC_W +: OPC_W]   & {OPC_W{gnt[i]}});
      mux_data = mux_data | (in_data[i*DATA_W +: DATA_W]   & {DATA_W{gnt[i]}});
      mux_src  = mux_src  | (in_src_id[i*ID_W +: ID_W]     & {ID_W{gnt[i]}});
      mux_tgt  = mux_tgt  | (in_tgt_id[i*ID_W +: ID_W]     & {ID_W{gnt[i]}});
    end
  end

  // fire/stall refer to the handshake right after the mux (slice input when the slice exists).
  assign fire      = mux_vld & down_rdy;
  assign stall     = mux_vld & ~down_rdy;
  assign in_rdy    = gnt & {NUM_IN{down_rdy}};
  assign update_en = gnt & {NUM_IN{fire & mux_last}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      gnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if ((fire && !mux_last) || stall) begin
            state_reg <= ST_LOCKED;
            gnt_reg   <= sel;
          end
        end
        ST_LOCKED: begin
          if (fire && mux_last) begin
            state_reg <= ST_IDLE;
            gnt_reg   <= '0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          gnt_reg   <= '0;
        end
      endcase
    end
  end

`ifdef TOY_BUS_ARB_OUT_SLICE_EN
  localparam int PW = 1 + OPC_W + DATA_W + 2*ID_W;

  logic          main_vld_reg;
  logic          skid_vld_reg;
  logic [PW-1:0] main_pay_reg;
  logic [PW-1:0] skid_pay_reg;
  logic [PW-1:0] mux_pay;

  assign mux_pay  = {mux_last, mux_opc, mux_data, mux_src, mux_tgt};
  assign down_rdy = ~skid_vld_reg;

  // Skid entry only fills when the output stalls; it drains first, so beat order is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_reg <= 1'b0;
      skid_vld_reg <= 1'b0;
      main_pay_reg <= '0;
      skid_pay_reg <= '0;
    end else if (!main_vld_reg || out0_rdy) begin
      if (skid_vld_reg) begin
        main_pay_reg <= skid_pay_reg;
        main_vld_reg <= 1'b1;
        skid_vld_reg <= 1'b0;
      end else if (fire) begin
        main_pay_reg <= mux_pay;
        main_vld_reg <= 1'b1;
      end else begin
        main_vld_reg <= 1'b0;
      end
    end else if (fire) begin
      skid_pay_reg <= mux_pay;
      skid_vld_reg <= 1'b1;
    end
  end

  assign out0_vld = main_vld_reg;
  assign {out0_last, out0_opcode, out0_data, out0_src_id, out0_tgt_id} = main_pay_reg;
`else
  assign down_rdy    = out0_rdy;
  assign out0_vld    = mux_vld;
  assign out0_last   = mux_last;
  assign out0_opcode = mux_opc;
  assign out0_data   = mux_data;
  assign out0_src_id = mux_src;
  assign out0_tgt_id = mux_tgt;
`endif

endmodule

// File: tb/tb_toy_bus_age_arb_lock_n.sv
// Self-checking bench for toy_bus_age_arb_lock_n (NUM_IN=4): directed arbitration scenarios plus a
// scoreboarded random stream; the combinational-latency checks run only without TOY_BUS_ARB_OUT_SLICE_EN.
module tb_toy_bus_age_arb_lock_n;

  localparam int N  = 4;
  localparam int OW = 1;
  localparam int DW = 32;
  localparam int IW = 4;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      in_vld;
  logic [N-1:0]      in_rdy;
  logic [N-1:0]      in_last;
  logic [N*OW-1:0]   in_opcode;
  logic [N*DW-1:0]   in_data;
  logic [N*IW-1:0]   in_src_id;
  logic [N*IW-1:0]   in_tgt_id;
  logic              out0_vld;
  logic              out0_rdy;
  logic              out0_last;
  logic [OW-1:0]     out0_opcode;
  logic [DW-1:0]     out0_data;
  logic [IW-1:0]     out0_src_id;
  logic [IW-1:0]     out0_tgt_id;
  logic [N-1:0]      out_gnt;

  int checks = 0;
  int errors = 0;
  logic proto_en = 1'b0;
  logic [N-1:0] hold_prev = '0;

  toy_bus_age_arb_lock_n #(.NUM_IN(N), .OPC_W(OW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .in_last     (in_last),
    .in_opcode   (in_opcode),
    .in_data     (in_data),
    .in_src_id   (in_src_id),
    .in_tgt_id   (in_tgt_id),
    .out0_vld    (out0_vld),
    .out0_rdy    (out0_rdy),
    .out0_last   (out0_last),
    .out0_opcode (out0_opcode),
    .out0_data   (out0_data),
    .out0_src_id (out0_src_id),
    .out0_tgt_id (out0_tgt_id),
    .out_gnt     (out_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A granted, stalled source must keep its valid asserted into the next cycle.
  always @(posedge clk) begin
    if (proto_en && rst_n) begin
      assert ((hold_prev & ~in_vld) == '0)
        else $error("protocol: source dropped vld while stalled, hold=%b vld=%b", hold_prev, in_vld);
    end
    hold_prev <= in_vld & out_gnt & ~in_rdy;
  end

  function automatic logic [DW-1:0] chan_data(int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  task automatic set_payload();
    for (int i = 0; i < N; i++) begin
      in_data[i*DW +: DW]   = chan_data(i);
      in_opcode[i*OW +: OW] = OW'(i & 1);
      in_src_id[i*IW +: IW] = IW'(i);
      in_tgt_id[i*IW +: IW] = IW'(N - 1 - i);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_vld   = '0;
    in_last  = '0;
    out0_rdy = 1'b0;
    set_payload();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_vld   = '0;
    in_last  = '1;
    out0_rdy = 1'b1;
    set_payload();
    #1;
    checks++; if (out0_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b expected 0", out0_vld); end
    checks++; if (in_rdy !== 4'b0000) begin errors++; $display("FAIL reset_in_rdy: got %b expected 0000", in_rdy); end
    checks++; if (out_gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", out_gnt); end
    checks++; if (out0_data !== 32'h0) begin errors++; $display("FAIL reset_payload: got %h expected 0", out0_data); end
    $display("test_reset: out0_vld=%b in_rdy=%b gnt=%b data=%h", out0_vld, in_rdy, out_gnt, out0_data);
    do_reset();
  endtask

  task automatic test_rotation();
    logic [N-1:0] exp_gnt;
    do_reset();
    in_vld   = 4'b1111;
    in_last  = 4'b1111;
    out0_rdy = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = N'(1) << (k % N);
      checks++; if (out_gnt !== exp_gnt) begin errors++; $display("FAIL rotate_gnt[%0d]: got %b expected %b", k, out_gnt, exp_gnt); end
      checks++; if (out0_data !== chan_data(k % N)) begin errors++; $display("FAIL rotate_data[%0d]: got %h expected %h", k, out0_data, chan_data(k % N)); end
      $display("test_rotation: beat %0d gnt=%b data=%h", k, out_gnt, out0_data);
      @(posedge clk);
      #1;
    end
    in_vld = '0;
  endtask

  task automatic test_lock();
    do_reset();
    out0_rdy = 1'b1;
    in_last  = 4'b1111;
    in_vld   = 4'b0001;   // age ch0 once so ch2 becomes older than ch0
    #1;
    checks++; if (out_gnt !== 4'b0001) begin errors++; $display("FAIL lock_prime_gnt: got %b expected 0001", out_gnt); end
    @(posedge clk);
    #1;
    in_vld = 4'b0101;
    for (int b = 0; b < 3; b++) begin
      in_last[2] = (b == 2);
      in_data[2*DW +: DW] = chan_data(2) + 32'(b);
      #1;
      checks++; if (out_gnt !== 4'b0100) begin errors++; $display("FAIL lock_gnt[%0d]: got %b expected 0100", b, out_gnt); end
      checks++; if (out0_data !== chan_data(2) + 32'(b)) begin errors++; $display("FAIL lock_data[%0d]: got %h expected %h", b, out0_data, chan_data(2) + 32'(b)); end
      $display("test_lock: beat %0d gnt=%b last=%b data=%h", b, out_gnt, out0_last, out0_data);
      @(posedge clk);
      #1;
    end
    in_vld[2] = 1'b0;
    #1;
    checks++; if (out_gnt !== 4'b0001) begin errors++; $display("FAIL lock_release_gnt: got %b expected 0001", out_gnt); end
    in_vld = '0;
    set_payload();
  endtask

  task automatic test_stall();
    do_reset();
    in_vld   = 4'b1010;
    in_last  = 4'b1111;
    out0_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) in_vld[0] = 1'b1;
      #1;
      checks++; if (out_gnt !== 4'b0010) begin errors++; $display("FAIL stall_gnt[%0d]: got %b expected 0010", c, out_gnt); end
      checks++; if (out0_data !== chan_data(1)) begin errors++; $display("FAIL stall_data[%0d]: got %h expected %h", c, out0_data, chan_data(1)); end
      checks++; if (in_rdy !== 4'b0000) begin errors++; $display("FAIL stall_in_rdy[%0d]: got %b expected 0000", c, in_rdy); end
      $display("test_stall: cycle %0d gnt=%b data=%h in_rdy=%b", c, out_gnt, out0_data, in_rdy);
      @(posedge clk);
      #1;
    end
    out0_rdy = 1'b1;
    #1;
    checks++; if (in_rdy !== 4'b0010) begin errors++; $display("FAIL stall_release_rdy: got %b expected 0010", in_rdy); end
    @(posedge clk);
    #1;
    in_vld[1] = 1'b0;
    #1;
    checks++; if (out_gnt !== 4'b0001) begin errors++; $display("FAIL stall_next_gnt: got %b expected 0001", out_gnt); end
    $display("test_stall: after release gnt=%b", out_gnt);
    in_vld = '0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    in_vld   = 4'b1000;
    in_last  = 4'b0000;
    out0_rdy = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_gnt !== 4'b1000) begin errors++; $display("FAIL midrst_locked_gnt: got %b expected 1000", out_gnt); end
    #1;
    rst_n  = 1'b0;
    in_vld = '0;
    #1;
    checks++; if (out0_vld !== 1'b0) begin errors++; $display("FAIL midrst_out_vld: got %b expected 0", out0_vld); end
    checks++; if (out_gnt !== 4'b0000) begin errors++; $display("FAIL midrst_gnt: got %b expected 0000", out_gnt); end
    in_vld  = 4'b1111;
    in_last = 4'b1111;
    #1;
    checks++; if (out_gnt !== 4'b0001) begin errors++; $display("FAIL midrst_first_gnt: got %b expected 0001", out_gnt); end
    @(negedge clk) rst_n = 1'b1;
    #1;
    checks++; if (out_gnt !== 4'b0001) begin errors++; $display("FAIL midrst_post_gnt: got %b expected 0001", out_gnt); end
    $display("test_reset_mid_burst: gnt after reset=%b", out_gnt);
    in_vld = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_no_leak();
    do_reset();
    in_vld   = '0;
    out0_rdy = 1'b1;
    in_data[0 +: DW] = 32'hDEAD_BEEF;
    #1;
    checks++; if (out0_data !== 32'h0) begin errors++; $display("FAIL noleak_data: got %h expected 0", out0_data); end
    checks++; if (in_rdy !== 4'b0000) begin errors++; $display("FAIL noleak_rdy: got %b expected 0000", in_rdy); end
    checks++; if (out0_vld !== 1'b0) begin errors++; $display("FAIL noleak_vld: got %b expected 0", out0_vld); end
    $display("test_no_leak: data=%h in_rdy=%b vld=%b", out0_data, in_rdy, out0_vld);
    set_payload();
  endtask

  task automatic test_random_stream();
    logic [DW:0]  exp_q[$];
    logic [DW:0]  exp_item;
    logic [N-1:0] fired;
    logic [N-1:0] open_pkt;
    int           seq[N];
    int           gen;
    int           sent;
    int           rcvd;
    int           cyc;
    do_reset();
    fired    = '0;
    open_pkt = '0;
    gen  = 0;
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    proto_en = 1'b1;
    while ((gen < 100 || open_pkt != '0 || in_vld != '0 || exp_q.size() != 0) && cyc < 3000) begin
      for (int i = 0; i < N; i++) begin
        if (fired[i]) in_vld[i] = 1'b0;
        if (!in_vld[i] && (open_pkt[i] || (gen < 100 && $urandom_range(0, 1) == 1))) begin
          in_vld[i] = 1'b1;
          in_data[i*DW +: DW] = {i[7:0], 24'(seq[i])};
          in_last[i] = (gen >= 99) ? 1'b1 : 1'($urandom_range(0, 1));
          open_pkt[i] = ~in_last[i];
          seq[i]++;
          gen++;
        end
      end
      out0_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      fired = in_vld & in_rdy;
      for (int i = 0; i < N; i++) begin
        if (fired[i]) begin
          exp_q.push_back({in_last[i], in_data[i*DW +: DW]});
          sent++;
        end
      end
      if (out0_vld && out0_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_unexpected: got %h with nothing outstanding", out0_data);
        end else begin
          exp_item = exp_q.pop_front();
          if ({out0_last, out0_data} !== exp_item) begin
            errors++;
            $display("FAIL rand_beat[%0d]: got last=%b data=%h expected last=%b data=%h",
                     rcvd, out0_last, out0_data, exp_item[DW], exp_item[DW-1:0]);
          end else begin
            $display("test_random_stream: beat %0d data=%h last=%b ok", rcvd, out0_data, out0_last);
          end
        end
        rcvd++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    proto_en = 1'b0;
    in_vld   = '0;
    checks++; if (cyc >= 3000) begin errors++; $display("FAIL rand_timeout: got %0d cycles expected under 3000", cyc); end
    checks++; if (rcvd !== sent) begin errors++; $display("FAIL rand_count: got %0d beats expected %0d", rcvd, sent); end
    checks++; if (sent < 100) begin errors++; $display("FAIL rand_sent: got %0d beats expected at least 100", sent); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_vld    = '0;
    in_last   = '0;
    out0_rdy  = 1'b0;
    in_data   = '0;
    in_opcode = '0;
    in_src_id = '0;
    in_tgt_id = '0;
`ifndef TOY_BUS_ARB_OUT_SLICE_EN
    test_reset();
    test_rotation();
    test_lock();
    test_stall();
    test_reset_mid_burst();
    test_no_leak();
`endif
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
